// File: rtl/gpio_in_pkg.sv
// -----------------------------------------------------------------------------
// gpio_in_pkg
// Shared types and default constants for the GPIO input debouncer.
//   gpio_in_state_e : per-channel debounce FSM state
//   DEB_CNT_DEF     : default stable-sample count (10 ms at 48 MHz)
//   CNT_W_DEF       : default debounce counter width
//   LONG_CNT_DEF    : default long-press threshold (2 s at 48 MHz)
//   pin_to_pressed  : raw pin level -> 1 = pressed, given the pin polarity
// Optional feature macro used by the importing modules: GPIO_IN_LONG_PRESS_EN
// -----------------------------------------------------------------------------
package gpio_in_pkg;

   typedef enum logic [1:0] {
      REL      = 2'd0,
      PRS_PEND = 2'd1,
      PRS      = 2'd2,
      REL_PEND = 2'd3
   } gpio_in_state_e;

   localparam int DEB_CNT_DEF  = 480000;
   localparam int CNT_W_DEF    = 20;
   localparam int LONG_CNT_DEF = 96000000;

   function automatic logic pin_to_pressed(input logic pin, input bit active_low);
      return active_low ? ~pin : pin;
   endfunction

endpackage

// File: rtl/gpio_in_chan.sv
// -----------------------------------------------------------------------------
// gpio_in_chan
// One debounced GPIO input: 2-flop synchronizer, polarity normalisation,
// debounce FSM with stable-sample counter and registered event strobes.
// With GPIO_IN_LONG_PRESS_EN defined, also a saturating long-press counter
// and a one-shot long_pulse.
//
// Ports
//   clk_osc       in   HFCLK, rising edge
//   reset         in   async, active high
//   gpio_in       in   raw asynchronous pin level
//   pressed       out  debounced level, 1 = pressed
//   press_pulse   out  one cycle on accepted released->pressed
//   release_pulse out  one cycle on accepted pressed->released
//   long_pulse    out  one cycle when held LONG_CNT cycles (macro only)
//
// State      | meaning
// -----------+-----------------------------------------------------------
// REL        | stable released, counter idle at 0
// PRS_PEND   | pressed samples seen, counting towards acceptance
// PRS        | stable pressed, counter idle at 0
// REL_PEND   | released samples seen, counting towards acceptance
// -----------------------------------------------------------------------------
module gpio_in_chan
   import gpio_in_pkg::*;
#(
   parameter int DEB_CNT    = DEB_CNT_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter bit ACTIVE_LOW = 1'b1
`ifdef GPIO_IN_LONG_PRESS_EN
   ,
   parameter int LONG_CNT   = LONG_CNT_DEF
`endif
) (
   input  logic clk_osc,
   input  logic reset,
   input  logic gpio_in,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse
`ifdef GPIO_IN_LONG_PRESS_EN
   ,
   output logic long_pulse
`endif
);

   // Synchronizer resets to the level an unpressed pin sits at, so a button
   // held through reset is seen as a fresh press afterwards.
   localparam logic             PIN_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic             smp;
   gpio_in_state_e   state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
         sync_q1 <= PIN_IDLE;
         sync_q2 <= PIN_IDLE;
      end else begin
         sync_q1 <= gpio_in;
         sync_q2 <= sync_q1;
      end
   end

   assign smp = pin_to_pressed(sync_q2, ACTIVE_LOW);

   // Counter holds the number of consecutive samples that disagree with the
   // accepted level; acceptance happens on the DEB_CNT-th such sample, so it
   // tops out at DEB_CNT-1 and cannot wrap.
   always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
         state         <= REL;
         cnt           <= '0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         case (state)
            REL: begin
               if (smp) begin
                  state <= PRS_PEND;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            PRS_PEND: begin
               if (!smp) begin
                  state <= REL;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state       <= PRS;
                  cnt         <= '0;
                  pressed     <= 1'b1;
                  press_pulse <= 1'b1;
               end else begin
                  cnt   <= cnt + CNT_ONE;
               end
            end
            PRS: begin
               if (!smp) begin
                  state <= REL_PEND;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            REL_PEND: begin
               if (smp) begin
                  state <= PRS;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state         <= REL;
                  cnt           <= '0;
                  pressed       <= 1'b0;
                  release_pulse <= 1'b1;
               end else begin
                  cnt   <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= REL;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef GPIO_IN_LONG_PRESS_EN
   localparam int                LONG_W    = $clog2(LONG_CNT + 1);
   localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
   localparam logic [LONG_W-1:0] LONG_TOP  = LONG_W'(LONG_CNT);
   localparam logic [LONG_W-1:0] LONG_PREV = LONG_W'(LONG_CNT - 1);

   logic [LONG_W-1:0] long_cnt;

   // Counts every cycle the debounced level is pressed (PRS or REL_PEND).
   // Saturation at LONG_CNT is what limits long_pulse to once per press.
   always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
         long_cnt   <= '0;
         long_pulse <= 1'b0;
      end else begin
         long_pulse <= 1'b0;
         if (state == PRS || state == REL_PEND) begin
            if (long_cnt != LONG_TOP) begin
               long_cnt   <= long_cnt + LONG_ONE;
               long_pulse <= (long_cnt == LONG_PREV);
            end
         end else begin
            long_cnt <= '0;
         end
      end
   end
`endif

endmodule

// File: rtl/gpio_input_debounce.sv
// -----------------------------------------------------------------------------
// gpio_input_debounce
// N_IN independent debounced GPIO inputs. Each bit gets its own
// gpio_in_chan (synchronizer, debounce FSM, counters); channels share only
// clock and reset. All outputs come straight from channel flops.
//
// Parameters
//   N_IN       number of channels, 1..16
//   DEB_CNT    stable samples needed to accept a level change, >= 2
//   CNT_W      debounce counter width, 2^CNT_W > DEB_CNT
//   ACTIVE_LOW 1: pin low = pressed, 0: pin high = pressed
//   LONG_CNT   pressed cycles before long_pulse (GPIO_IN_LONG_PRESS_EN only)
//
// Ports
//   clk_osc       in   HFCLK, rising edge
//   reset         in   async, active high
//   gpio_in       in   [N_IN] raw pin levels
//   pressed       out  [N_IN] debounced level, 1 = pressed
//   press_pulse   out  [N_IN] one-cycle press strobe
//   release_pulse out  [N_IN] one-cycle release strobe
//   long_pulse    out  [N_IN] one-cycle long-press strobe (macro only)
//
// Build option: define GPIO_IN_LONG_PRESS_EN to add long-press detection.
// -----------------------------------------------------------------------------
module gpio_input_debounce
   import gpio_in_pkg::*;
#(
   parameter int N_IN       = 2,
   parameter int DEB_CNT    = DEB_CNT_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int LONG_CNT   = LONG_CNT_DEF
) (
   input  logic            clk_osc,
   input  logic            reset,
   input  logic [N_IN-1:0] gpio_in,
   output logic [N_IN-1:0] pressed,
   output logic [N_IN-1:0] press_pulse,
   output logic [N_IN-1:0] release_pulse
`ifdef GPIO_IN_LONG_PRESS_EN
   ,
   output logic [N_IN-1:0] long_pulse
`endif
);

   // Reject parameter sets the counters cannot represent.
   if (N_IN < 1 || N_IN > 16 || DEB_CNT < 2 || CNT_W < 1 || CNT_W > 30 ||
       (1 << CNT_W) <= DEB_CNT || LONG_CNT < 1) begin : g_bad_params
      $error("gpio_input_debounce: illegal parameter combination");
   end

   for (genvar i = 0; i < N_IN; i++) begin : g_chan
      gpio_in_chan #(
         .DEB_CNT    (DEB_CNT),
         .CNT_W      (CNT_W),
         .ACTIVE_LOW (ACTIVE_LOW)
`ifdef GPIO_IN_LONG_PRESS_EN
         ,
         .LONG_CNT   (LONG_CNT)
`endif
      ) u_chan (
         .clk_osc       (clk_osc),
         .reset         (reset),
         .gpio_in       (gpio_in[i]),
         .pressed       (pressed[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
`ifdef GPIO_IN_LONG_PRESS_EN
         ,
         .long_pulse    (long_pulse[i])
`endif
      );
   end

endmodule
